peak_detector_adaptive: RTL



---
 rtl/peak_detector_adaptive_pkg.sv | 28 ++
 rtl/peak_detector_adaptive_env_tracker.sv | 68 ++++++
 rtl/peak_detector_adaptive.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/peak_detector_adaptive_pkg.sv
// peak_pkg: shared definitions for the adaptive PPG peak detector.
//   - default parameter values for the top and the envelope tracker
//   - FSM state type
//   - sat_add: integer add that clamps at an upper bound
package peak_pkg;

  localparam int WIDTH_DEF        = 10;
  localparam int THRESH_MIN_DEF   = 50;
  localparam int REF_PERIOD_DEF   = 8;
  localparam int ENV_SH_DEF       = 2;
  localparam int THR_SH_DEF       = 2;
  localparam int DECAY_PERIOD_DEF = 64;
  localparam int CNT_W_DEF        = 12;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    RISING  = 2'd1,
    REFRACT = 2'd2
  } state_e;

  // Callers truncate the result to their own width; max_v must fit it.
  function automatic int sat_add(input int a, input int b, input int max_v);
    int s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/peak_detector_adaptive_env_tracker.sv
// peak_env_tracker: leaky envelope of recent peak amplitudes and the
// detection threshold derived from it.
//   clk, rst_n    : clock, asynchronous active-low reset
//   update_i      : a peak was confirmed; pull env towards peak_amp_i
//   decay_tick_i  : one accepted sub-threshold sample seen in SEARCH
//   peak_amp_i    : signed amplitude of the confirmed peak
//   thr_o         : signed threshold, env - env>>>THR_SH, floored at THRESH_MIN
module peak_env_tracker
  import peak_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int THRESH_MIN   = THRESH_MIN_DEF,
  parameter int ENV_SH       = ENV_SH_DEF,
  parameter int THR_SH       = THR_SH_DEF,
  parameter int DECAY_PERIOD = DECAY_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             update_i,
  input  logic             decay_tick_i,
  input  logic [WIDTH-1:0] peak_amp_i,
  output logic [WIDTH-1:0] thr_o
);

  localparam int DC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECAY_PERIOD - 1);
  localparam logic signed [WIDTH:0] T_MIN = (WIDTH+1)'(THRESH_MIN);
  localparam int ENV_MAX = (1 << (WIDTH - 1)) - 1;

  logic signed [WIDTH-1:0] env_q, env_d;
  logic [DC_W-1:0]         decay_cnt_q, decay_cnt_d;
  logic signed [WIDTH:0]   env_x, amp_x, thr_raw, step_up, dec_raw;

  always_comb begin
    // One extra bit so differences and subtractions cannot wrap.
    env_x   = {env_q[WIDTH-1], env_q};
    amp_x   = {peak_amp_i[WIDTH-1], peak_amp_i};
    thr_raw = env_x - (env_x >>> THR_SH);
    step_up = (amp_x - env_x) >>> ENV_SH;
    dec_raw = env_x - (env_x >>> ENV_SH);
    thr_o   = WIDTH'((thr_raw < T_MIN) ? T_MIN : thr_raw);

    env_d       = env_q;
    decay_cnt_d = decay_cnt_q;
    if (update_i) begin
      env_d       = WIDTH'(sat_add(int'(env_x), int'(step_up), ENV_MAX));
      decay_cnt_d = '0;
    end else if (decay_tick_i) begin
      if (decay_cnt_q == DC_LAST) begin
        env_d       = WIDTH'((dec_raw < T_MIN) ? T_MIN : dec_raw);
        decay_cnt_d = '0;
      end else begin
        decay_cnt_d = decay_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q       <= WIDTH'(THRESH_MIN);
      decay_cnt_q <= '0;
    end else begin
      env_q       <= env_d;
      decay_cnt_q <= decay_cnt_d;
    end
  end

endmodule

// File: rtl/peak_detector_adaptive.sv
// peak_detector_adaptive: systolic peak detector for a down-sampled PPG
// stream with an adaptive threshold and inter-beat interval output.
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : block enable; low freezes all state
//   valid_in      : ppg_in valid; a sample is accepted when en && valid_in
//   ppg_in        : signed sample
//   peak_detected : one-cycle pulse, cycle after the confirming sample
//   peak_value    : signed amplitude of the last peak (held)
//   ibi_samples   : last inter-beat interval in accepted samples (held)
//   ibi_valid     : pulses with peak_detected when ibi_samples was updated
//   threshold     : current effective threshold
// Handshake: there is no back-pressure; every cycle with en && valid_in
// consumes exactly one sample, other cycles change nothing except that
// the two pulse outputs return to 0.
module peak_detector_adaptive
  import peak_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int THRESH_MIN   = THRESH_MIN_DEF,
  parameter int REF_PERIOD   = REF_PERIOD_DEF,
  parameter int ENV_SH       = ENV_SH_DEF,
  parameter int THR_SH       = THR_SH_DEF,
  parameter int DECAY_PERIOD = DECAY_PERIOD_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] ppg_in,
  output logic             peak_detected,
  output logic [WIDTH-1:0] peak_value,
  output logic [CNT_W-1:0] ibi_samples,
  output logic             ibi_valid,
  output logic [WIDTH-1:0] threshold
);

  localparam int RC_W    = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] max_q, max_d;
  logic [RC_W-1:0]         ref_cnt_q, ref_cnt_d;
  logic [CNT_W-1:0]        ibi_cnt_q, ibi_cnt_d;
  logic                    first_seen_q, first_seen_d;
  logic                    peak_det_q, peak_det_d;
  logic [WIDTH-1:0]        peak_val_q, peak_val_d;
  logic [CNT_W-1:0]        ibi_samp_q, ibi_samp_d;
  logic                    ibi_val_q, ibi_val_d;

  logic                    accept, confirm, decay_tick;
  logic signed [WIDTH-1:0] x, thr_s;
  logic [WIDTH-1:0]        thr_w;

  peak_env_tracker #(
    .WIDTH       (WIDTH),
    .THRESH_MIN  (THRESH_MIN),
    .ENV_SH      (ENV_SH),
    .THR_SH      (THR_SH),
    .DECAY_PERIOD(DECAY_PERIOD)
  ) u_env (
    .clk         (clk),
    .rst_n       (rst_n),
    .update_i    (confirm),
    .decay_tick_i(decay_tick),
    .peak_amp_i  (max_q),
    .thr_o       (thr_w)
  );

  always_comb begin
    accept       = en & valid_in;
    x            = ppg_in;
    thr_s        = thr_w;
    confirm      = 1'b0;
    decay_tick   = 1'b0;
    state_d      = state_q;
    max_d        = max_q;
    ref_cnt_d    = ref_cnt_q;
    ibi_cnt_d    = ibi_cnt_q;
    first_seen_d = first_seen_q;
    peak_det_d   = 1'b0;
    peak_val_d   = peak_val_q;
    ibi_samp_d   = ibi_samp_q;
    ibi_val_d    = 1'b0;

    if (accept) begin
      ibi_cnt_d = CNT_W'(sat_add(int'(ibi_cnt_q), 1, CNT_MAX));
      case (state_q)
        SEARCH: begin
          if (x > thr_s) begin
            state_d = RISING;
            max_d   = x;
          end else begin
            decay_tick = 1'b1;
          end
        end
        RISING: begin
          // Equal samples are a plateau: keep waiting for the fall.
          if (x > max_q) max_d = x;
          else if (x < max_q) confirm = 1'b1;
        end
        REFRACT: begin
          if (ref_cnt_q == '0) state_d = SEARCH;
          else ref_cnt_d = ref_cnt_q - 1'b1;
        end
        default: state_d = SEARCH;
      endcase

      if (confirm) begin
        peak_det_d   = 1'b1;
        peak_val_d   = max_q;
        ibi_cnt_d    = '0;
        first_seen_d = 1'b1;
        // The interval includes the confirming sample itself.
        if (first_seen_q) begin
          ibi_samp_d = CNT_W'(sat_add(int'(ibi_cnt_q), 1, CNT_MAX));
          ibi_val_d  = 1'b1;
        end
        if (REF_PERIOD == 0) begin
          state_d = SEARCH;
        end else begin
          state_d   = REFRACT;
          ref_cnt_d = RC_W'(REF_PERIOD - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      max_q        <= '0;
      ref_cnt_q    <= '0;
      ibi_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      peak_det_q   <= 1'b0;
      peak_val_q   <= '0;
      ibi_samp_q   <= '0;
      ibi_val_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      max_q        <= max_d;
      ref_cnt_q    <= ref_cnt_d;
      ibi_cnt_q    <= ibi_cnt_d;
      first_seen_q <= first_seen_d;
      peak_det_q   <= peak_det_d;
      peak_val_q   <= peak_val_d;
      ibi_samp_q   <= ibi_samp_d;
      ibi_val_q    <= ibi_val_d;
    end
  end

  assign peak_detected = peak_det_q;
  assign peak_value    = peak_val_q;
  assign ibi_samples   = ibi_samp_q;
  assign ibi_valid     = ibi_val_q;
  assign threshold     = thr_w;

endmodule
